// File: rtl/ipif_pkg.sv
// Shared definitions for the AXI4-Lite to IPIF bridge: response codes and
// the bridge FSM state type.
package ipif_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_WAIT = 3'd1,
    RD_WAIT = 3'd2,
    B_RESP  = 3'd3,
    R_RESP  = 3'd4
  } bridge_state_t;

endpackage

// File: rtl/ipif_reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the
// second clock edge after the incoming reset is released.
module ipif_reset_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_rst_n
);

  logic r_meta;
  logic r_sync;

  // Shift a one through two flops once reset is released
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= 1'b1;
      r_sync <= r_meta;
    end
  end

  assign o_rst_n = r_sync;

endmodule

// File: rtl/axi_lite_ipif_bridge.sv
// AXI4-Lite slave turning single accesses into one-hot IPIF chip enables.
// One transaction in flight; reads and writes arbitrated round-robin.
// Optional macro IPIF_BRIDGE_TIMEOUT_EN: ack timeout answering SLVERR.
module axi_lite_ipif_bridge
  import ipif_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int N_REG              = 2,
  parameter int C_LOCAL_ADDR_BITS  = 12,
  parameter int C_TIMEOUT          = 64
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   IPIF_bus2ip_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_bus2ip_data,
  output logic [N_REG-1:0]                IPIF_bus2ip_wrce,
  output logic [N_REG-1:0]                IPIF_bus2ip_rdce,
  output logic                            IPIF_bus2ip_resetn,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_ip2bus_data,
  input  logic                            IPIF_ip2bus_wrack,
  input  logic                            IPIF_ip2bus_rdack
);

  localparam int IW = C_LOCAL_ADDR_BITS - 2;

  bridge_state_t                 r_state, w_state_nxt;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  logic [N_REG-1:0]              r_wrce, w_wrce_nxt;
  logic [N_REG-1:0]              r_rdce, w_rdce_nxt;
  logic [1:0]                    r_bresp, w_bresp_nxt;
  logic [1:0]                    r_rresp, w_rresp_nxt;
  logic                          r_bvalid, w_bvalid_nxt;
  logic                          r_rvalid, w_rvalid_nxt;
  logic                          r_last_was_write, w_last_was_write_nxt;

  logic                          w_rd_elig, w_wr_elig, w_grant_rd, w_grant_wr;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_sel_addr, w_addr_local;
  logic [IW-1:0]                 w_index;
  logic [N_REG-1:0]              w_onehot;
  logic                          w_dec_err;
  logic                          w_in_wait;
  logic                          w_timeout;
  logic                          w_unused_tmo;
  logic                          w_unused_ok;

  assign w_in_wait = (r_state == WR_WAIT) || (r_state == RD_WAIT);

`ifdef IPIF_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(C_TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt;

  // Count cycles spent waiting for an ack; idle time keeps it cleared so it starts at zero on entry
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_tmo_cnt <= '0;
    end else if (w_in_wait) begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_timeout    = w_in_wait && (r_tmo_cnt == TW'(C_TIMEOUT - 1));
  assign w_unused_tmo = 1'b0;
`else
  assign w_timeout    = 1'b0;
  assign w_unused_tmo = (C_TIMEOUT == 0);
`endif

  // Protection bits and the undecoded upper address bits carry no meaning here
  assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_unused_tmo,
                         S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:C_LOCAL_ADDR_BITS],
                         S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:C_LOCAL_ADDR_BITS]};

  // Round-robin grant between an eligible read and an eligible write in IDLE
  always_comb begin
    w_rd_elig  = (r_state == IDLE) && S_AXI_ARVALID && S_AXI_ARESETN;
    w_wr_elig  = (r_state == IDLE) && S_AXI_AWVALID && S_AXI_WVALID && S_AXI_ARESETN;
    w_grant_rd = w_rd_elig && (!w_wr_elig || r_last_was_write);
    w_grant_wr = w_wr_elig && !w_grant_rd;
  end

  assign S_AXI_AWREADY = w_grant_wr;
  assign S_AXI_WREADY  = w_grant_wr;
  assign S_AXI_ARREADY = w_grant_rd;

  // Decode the granted address: local offset, word index, range check, one-hot CE
  always_comb begin
    w_sel_addr   = w_grant_wr ? S_AXI_AWADDR : S_AXI_ARADDR;
    w_addr_local = '0;
    w_addr_local[C_LOCAL_ADDR_BITS-1:0] = w_sel_addr[C_LOCAL_ADDR_BITS-1:0];
    w_index      = w_sel_addr[C_LOCAL_ADDR_BITS-1:2];
    w_dec_err    = (32'(w_index) >= 32'(N_REG));
    for (int i = 0; i < N_REG; i++) begin
      w_onehot[i] = (32'(w_index) == 32'(i));
    end
  end

  // Next-state and next-output logic of the bridge FSM
  always_comb begin
    w_state_nxt          = r_state;
    w_addr_nxt           = r_addr;
    w_data_nxt           = r_data;
    w_rdata_nxt          = r_rdata;
    w_wrce_nxt           = r_wrce;
    w_rdce_nxt           = r_rdce;
    w_bresp_nxt          = r_bresp;
    w_rresp_nxt          = r_rresp;
    w_bvalid_nxt         = r_bvalid;
    w_rvalid_nxt         = r_rvalid;
    w_last_was_write_nxt = r_last_was_write;
    case (r_state)
      IDLE: begin
        if (w_grant_rd) begin
          w_last_was_write_nxt = 1'b0;
          w_addr_nxt           = w_addr_local;
          if (w_dec_err) begin
            w_rresp_nxt  = RESP_DECERR;
            w_rdata_nxt  = '0;
            w_rvalid_nxt = 1'b1;
            w_state_nxt  = R_RESP;
          end else begin
            w_rdce_nxt  = w_onehot;
            w_state_nxt = RD_WAIT;
          end
        end else if (w_grant_wr) begin
          w_last_was_write_nxt = 1'b1;
          w_addr_nxt           = w_addr_local;
          w_data_nxt           = S_AXI_WDATA;
          if (w_dec_err) begin
            w_bresp_nxt  = RESP_DECERR;
            w_bvalid_nxt = 1'b1;
            w_state_nxt  = B_RESP;
          end else if (!(&S_AXI_WSTRB)) begin
            w_bresp_nxt  = RESP_SLVERR;
            w_bvalid_nxt = 1'b1;
            w_state_nxt  = B_RESP;
          end else begin
            w_wrce_nxt  = w_onehot;
            w_state_nxt = WR_WAIT;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WR_WAIT: begin
        if (IPIF_ip2bus_wrack) begin
          w_wrce_nxt   = '0;
          w_bresp_nxt  = RESP_OKAY;
          w_bvalid_nxt = 1'b1;
          w_state_nxt  = B_RESP;
        end else if (w_timeout) begin
          w_wrce_nxt   = '0;
          w_bresp_nxt  = RESP_SLVERR;
          w_bvalid_nxt = 1'b1;
          w_state_nxt  = B_RESP;
        end else begin
          w_state_nxt = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (IPIF_ip2bus_rdack) begin
          w_rdce_nxt   = '0;
          w_rresp_nxt  = RESP_OKAY;
          w_rdata_nxt  = IPIF_ip2bus_data;
          w_rvalid_nxt = 1'b1;
          w_state_nxt  = R_RESP;
        end else if (w_timeout) begin
          w_rdce_nxt   = '0;
          w_rresp_nxt  = RESP_SLVERR;
          w_rdata_nxt  = '0;
          w_rvalid_nxt = 1'b1;
          w_state_nxt  = R_RESP;
        end else begin
          w_state_nxt = RD_WAIT;
        end
      end
      B_RESP: begin
        if (S_AXI_BREADY) begin
          w_bvalid_nxt = 1'b0;
          w_state_nxt  = IDLE;
        end else begin
          w_state_nxt = B_RESP;
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          w_rvalid_nxt = 1'b0;
          w_state_nxt  = IDLE;
        end else begin
          w_state_nxt = R_RESP;
        end
      end
      default: begin
        w_wrce_nxt   = '0;
        w_rdce_nxt   = '0;
        w_bvalid_nxt = 1'b0;
        w_rvalid_nxt = 1'b0;
        w_state_nxt  = IDLE;
      end
    endcase
  end

  // State and registered outputs; everything clears asynchronously on reset
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state          <= IDLE;
      r_addr           <= '0;
      r_data           <= '0;
      r_rdata          <= '0;
      r_wrce           <= '0;
      r_rdce           <= '0;
      r_bresp          <= RESP_OKAY;
      r_rresp          <= RESP_OKAY;
      r_bvalid         <= 1'b0;
      r_rvalid         <= 1'b0;
      r_last_was_write <= 1'b1;
    end else begin
      r_state          <= w_state_nxt;
      r_addr           <= w_addr_nxt;
      r_data           <= w_data_nxt;
      r_rdata          <= w_rdata_nxt;
      r_wrce           <= w_wrce_nxt;
      r_rdce           <= w_rdce_nxt;
      r_bresp          <= w_bresp_nxt;
      r_rresp          <= w_rresp_nxt;
      r_bvalid         <= w_bvalid_nxt;
      r_rvalid         <= w_rvalid_nxt;
      r_last_was_write <= w_last_was_write_nxt;
    end
  end

  assign S_AXI_BRESP      = r_bresp;
  assign S_AXI_BVALID     = r_bvalid;
  assign S_AXI_RRESP      = r_rresp;
  assign S_AXI_RVALID     = r_rvalid;
  assign S_AXI_RDATA      = r_rdata;
  assign IPIF_bus2ip_addr = r_addr;
  assign IPIF_bus2ip_data = r_data;
  assign IPIF_bus2ip_wrce = r_wrce;
  assign IPIF_bus2ip_rdce = r_rdce;

  ipif_reset_sync u_rst_sync (
    .i_clk   (S_AXI_ACLK),
    .i_rst_n (S_AXI_ARESETN),
    .o_rst_n (IPIF_bus2ip_resetn)
  );

endmodule

// File: tb/tb_axi_lite_ipif_bridge.sv
// Self-checking bench for axi_lite_ipif_bridge with a small IPIF register
// bank model that acks one cycle after CE. Optional macro:
// IPIF_BRIDGE_TIMEOUT_EN (enables the ack-timeout sequence).
module tb_axi_lite_ipif_bridge;
  import ipif_pkg::*;

  localparam int NR = 2;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [NR-1:0] ce;
    int          ce_cyc;
    int          lat;
  } vec_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   awaddr, wdata, araddr, rdata, b2ip_addr, b2ip_data, ip2b_data;
  logic [3:0]    wstrb;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [1:0]    bresp, rresp;
  logic [NR-1:0] wrce, rdce;
  logic          b2ip_resetn, wrack, rdack, r_wrack, r_rdack;
  logic          ack_en, stray_wrack;
  logic [31:0]   bank [NR];

  int   errors = 0;
  int   checks = 0;
  exp_t q_exp[$];
  vec_t vecs[13];

  always #5 clk = ~clk;

  axi_lite_ipif_bridge #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32), .N_REG(NR),
    .C_LOCAL_ADDR_BITS(12), .C_TIMEOUT(8)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .IPIF_bus2ip_addr(b2ip_addr), .IPIF_bus2ip_data(b2ip_data),
    .IPIF_bus2ip_wrce(wrce), .IPIF_bus2ip_rdce(rdce), .IPIF_bus2ip_resetn(b2ip_resetn),
    .IPIF_ip2bus_data(ip2b_data), .IPIF_ip2bus_wrack(wrack), .IPIF_ip2bus_rdack(rdack)
  );

  // Register bank model: acks one cycle after seeing CE, for as long as CE is held
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrack <= 1'b0;
      r_rdack <= 1'b0;
    end else begin
      r_wrack <= ack_en && (|wrce);
      r_rdack <= ack_en && (|rdce);
    end
  end

  // Bank storage written whenever its write enable is high
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) if (wrce[i]) bank[i] <= b2ip_data;
  end

  // Read mux of the bank
  always_comb begin
    ip2b_data = 32'h0;
    for (int i = 0; i < NR; i++) if (rdce[i]) ip2b_data = bank[i];
  end

  assign wrack = r_wrack | stray_wrack;
  assign rdack = r_rdack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Wait for the response, monitoring CE, then pop the scoreboard and compare.
  task automatic wait_resp(input bit is_rd, output int lat, output int ce_cnt,
                           output logic [NR-1:0] ce_seen, output logic [31:0] addr_seen);
    bit   got;
    exp_t e;
    got = 1'b0; lat = 0; ce_cnt = 0; ce_seen = '0; addr_seen = 32'h0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if ((is_rd ? rdce : wrce) != '0) begin
        ce_cnt++;
        ce_seen   = ce_seen | (is_rd ? rdce : wrce);
        addr_seen = b2ip_addr;
      end
      got = is_rd ? rvalid : bvalid;
    end
    check("resp_seen", {31'b0, got}, 32'd1);
    if (q_exp.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = q_exp.pop_front();
      if (got) begin
        check(is_rd ? "rresp" : "bresp", {30'b0, is_rd ? rresp : bresp}, {30'b0, e.resp});
        if (is_rd) check("rdata", rdata, e.rdata);
      end
    end
    if (is_rd) rready = 1'b1; else bready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; bready = 1'b0;
  endtask

  // Drive one access from a vector record and compare handshake, CE and response.
  task automatic run_txn(input vec_t v);
    bit              hs;
    exp_t            e;
    int              lat, ce_cnt;
    logic [NR-1:0]   ce_seen;
    logic [31:0]     addr_seen;
    e.resp = v.resp; e.rdata = v.rdata;
    q_exp.push_back(e);
    @(negedge clk);
    if (v.wr) begin
      awaddr = v.addr; wdata = v.data; wstrb = v.strb; awvalid = 1'b1; wvalid = 1'b1;
    end else begin
      araddr = v.addr; arvalid = 1'b1;
    end
    hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) begin
      #1;
      hs = v.wr ? (awready && wready) : arready;
      @(posedge clk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("handshake", {31'b0, hs}, 32'd1);
    wait_resp(!v.wr, lat, ce_cnt, ce_seen, addr_seen);
    check("resp_latency", lat, v.lat);
    check("ce_cycles", ce_cnt, v.ce_cyc);
    check("ce_value", {{(32-NR){1'b0}}, ce_seen}, {{(32-NR){1'b0}}, v.ce});
    if (v.ce != '0) check("ipif_addr", addr_seen, v.addr & 32'h0000_0FFF);
  endtask

  // Global watchdog so the run can never hang
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   exp_rd, got, bad;
    int   lat, ce_cnt;
    logic [NR-1:0] ce_seen;
    logic [31:0]   addr_seen;
    exp_t e;
    vec_t v;

    for (int i = 0; i < NR; i++) bank[i] = 32'h0;
    rst_n = 1'b0; ack_en = 1'b1; stray_wrack = 1'b0;
    awaddr = 32'h0; wdata = 32'h0; wstrb = 4'h0; araddr = 32'h0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;

    //           wr    addr           data           strb   resp         rdata          ce     cyc lat
    vecs[0]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, RESP_OKAY,   32'h0,         2'b10, 2, 3};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, RESP_OKAY,   32'hDEAD_BEEF, 2'b10, 2, 3};
    vecs[2]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, RESP_OKAY,   32'h0,         2'b01, 2, 3};
    vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, RESP_OKAY,   32'h1234_5678, 2'b01, 2, 3};
    vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, RESP_DECERR, 32'h0,         2'b00, 0, 1};
    vecs[5]  = '{1'b1, 32'h0000_0000, 32'hAAAA_5555, 4'h3, RESP_SLVERR, 32'h0,         2'b00, 0, 1};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, RESP_OKAY,   32'h1234_5678, 2'b01, 2, 3};
    vecs[7]  = '{1'b1, 32'hFFFF_F004, 32'hCAFE_F00D, 4'hF, RESP_OKAY,   32'h0,         2'b10, 2, 3};
    vecs[8]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, RESP_DECERR, 32'h0,         2'b00, 0, 1};
    vecs[9]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, RESP_OKAY,   32'hCAFE_F00D, 2'b10, 2, 3};
    vecs[10] = '{1'b1, 32'h0000_0010, 32'h5555_AAAA, 4'hF, RESP_DECERR, 32'h0,         2'b00, 0, 1};
    vecs[11] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, RESP_DECERR, 32'h0,         2'b00, 0, 1};
    vecs[12] = '{1'b0, 32'hABCD_E000, 32'h0,         4'h0, RESP_OKAY,   32'h1234_5678, 2'b01, 2, 3};

    // Reset state, with valids asserted to show READY stays low in reset
    repeat (3) @(negedge clk);
    check("rst_ready", {29'b0, arready, awready, wready}, 32'h0);
    check("rst_valid", {30'b0, bvalid, rvalid}, 32'h0);
    check("rst_resp", {28'b0, bresp, rresp}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_ce", {28'b0, wrce, rdce}, 32'h0);
    check("rst_ipif_addr", b2ip_addr, 32'h0);
    check("rst_ipif_data", b2ip_data, 32'h0);
    check("rst_ipif_resetn", {31'b0, b2ip_resetn}, 32'h0);

    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("resetn_after_1clk", {31'b0, b2ip_resetn}, 32'h0);
    @(posedge clk); #1;
    check("resetn_after_2clk", {31'b0, b2ip_resetn}, 32'h1);

    // Persistent read/write collision: grants must alternate, read first
    @(negedge clk);
    awaddr = 32'h4; wdata = 32'h1111_1111; wstrb = 4'hF; araddr = 32'h4;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_rd  = (k % 2 == 0);
      e.resp  = RESP_OKAY;
      e.rdata = (k == 0) ? 32'h0 : 32'h1111_1111;
      q_exp.push_back(e);
      #1;
      check("rr_grant_rd", {31'b0, arready}, {31'b0, exp_rd});
      check("rr_grant_wr", {31'b0, awready && wready}, {31'b0, !exp_rd});
      @(posedge clk); #1;
      wait_resp(exp_rd, lat, ce_cnt, ce_seen, addr_seen);
      @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;

    // Main table of single accesses
    for (int i = 0; i < 13; i++) run_txn(vecs[i]);

    // BREADY held low five cycles, with a stray wrack while the response waits
    @(negedge clk);
    awaddr = 32'h0; wdata = 32'h0BAD_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    #1 check("hold_awready", {31'b0, awready}, 32'h1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bvalid;
    end
    check("hold_bvalid_seen", {31'b0, got}, 32'h1);
    for (int c = 0; c < 5; c++) begin
      stray_wrack = (c == 2);
      check("hold_bvalid", {31'b0, bvalid}, 32'h1);
      check("hold_bresp", {30'b0, bresp}, {30'b0, RESP_OKAY});
      check("hold_no_wrce", {30'b0, wrce}, 32'h0);
      @(negedge clk);
    end
    stray_wrack = 1'b0;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("hold_bvalid_clear", {31'b0, bvalid}, 32'h0);
    v = '{1'b0, 32'h0, 32'h0, 4'h0, RESP_OKAY, 32'h0BAD_F00D, 2'b01, 2, 3};
    run_txn(v);

`ifdef IPIF_BRIDGE_TIMEOUT_EN
    // Bank never acks: CE high for C_TIMEOUT cycles, then SLVERR with zero data
    ack_en = 1'b0;
    v = '{1'b0, 32'h0, 32'h0, 4'h0, RESP_SLVERR, 32'h0, 2'b01, 8, 9};
    run_txn(v);
    ack_en = 1'b1;
`endif

    // Reset while waiting for a read ack
    ack_en = 1'b0;
    @(negedge clk);
    araddr = 32'h4; arvalid = 1'b1;
    #1 check("rst_txn_arready", {31'b0, arready}, 32'h1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("rst_txn_rdce_before", {30'b0, rdce}, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_txn_rdce", {30'b0, rdce}, 32'h0);
    check("rst_txn_rvalid", {31'b0, rvalid}, 32'h0);
    check("rst_txn_resetn", {31'b0, b2ip_resetn}, 32'h0);
    check("rst_txn_addr", b2ip_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; ack_en = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rvalid || (rdce != '0)) bad = 1'b1;
    end
    check("rst_txn_no_resp", {31'b0, bad}, 32'h0);
    check("sb_drained", q_exp.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
